// File: rtl/diagonal_attackers.sv
// Sequential reverse lookup for diagonal sliders: walks the four diagonal rays out from a
// target square, one square per clock, and collects the enemy bishops/queens that see it.
module diagonal_attackers (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] occupied,
  input  logic [63:0] sliders,
  input  logic [2:0]  file,
  input  logic [2:0]  rank,
  output logic        busy,
  output logic        done,
  output logic [63:0] attackers,
  output logic [2:0]  attack_count
);

  typedef enum logic [1:0] {StIdle, StWalk, StDone} state_e;

  // Direction encoding: bit 0 set means file decreases, bit 1 set means rank decreases.
  localparam logic [1:0] DirNE = 2'd0;
  localparam logic [1:0] DirSW = 2'd3;

  state_e      state_q, state_d;
  logic [63:0] occ_q, occ_d;
  logic [63:0] sld_q, sld_d;
  logic [2:0]  tgt_file_q, tgt_file_d;
  logic [2:0]  tgt_rank_q, tgt_rank_d;
  logic [2:0]  cur_file_q, cur_file_d;
  logic [2:0]  cur_rank_q, cur_rank_d;
  logic [1:0]  dir_q, dir_d;
  logic [63:0] attackers_q, attackers_d;
  logic [2:0]  count_q, count_d;

  logic        file_dec, rank_dec;
  logic        off_board;
  logic [2:0]  next_file, next_rank;
  logic [5:0]  next_idx;

  always_comb begin
    file_dec  = dir_q[0];
    rank_dec  = dir_q[1];
    off_board = (file_dec ? (cur_file_q == 3'd0) : (cur_file_q == 3'd7)) ||
                (rank_dec ? (cur_rank_q == 3'd0) : (cur_rank_q == 3'd7));
    next_file = file_dec ? cur_file_q - 3'd1 : cur_file_q + 3'd1;
    next_rank = rank_dec ? cur_rank_q - 3'd1 : cur_rank_q + 3'd1;
    next_idx  = {next_rank, next_file};
  end

  always_comb begin
    state_d     = state_q;
    occ_d       = occ_q;
    sld_d       = sld_q;
    tgt_file_d  = tgt_file_q;
    tgt_rank_d  = tgt_rank_q;
    cur_file_d  = cur_file_q;
    cur_rank_d  = cur_rank_q;
    dir_d       = dir_q;
    attackers_d = attackers_q;
    count_d     = count_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          occ_d       = occupied;
          sld_d       = sliders;
          tgt_file_d  = file;
          tgt_rank_d  = rank;
          cur_file_d  = file;
          cur_rank_d  = rank;
          dir_d       = DirNE;
          attackers_d = '0;
          count_d     = '0;
          state_d     = StWalk;
        end
      end
      StWalk: begin
        if (!off_board && !occ_q[next_idx]) begin
          cur_file_d = next_file;
          cur_rank_d = next_rank;
        end else begin
          // Ray ends here: either it left the board or hit the first occupied square.
          if (!off_board && sld_q[next_idx]) begin
            attackers_d[next_idx] = 1'b1;
            count_d               = count_q + 3'd1;
          end
          cur_file_d = tgt_file_q;
          cur_rank_d = tgt_rank_q;
          if (dir_q == DirSW) begin
            state_d = StDone;
          end else begin
            dir_d = dir_q + 2'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      occ_q       <= '0;
      sld_q       <= '0;
      tgt_file_q  <= '0;
      tgt_rank_q  <= '0;
      cur_file_q  <= '0;
      cur_rank_q  <= '0;
      dir_q       <= '0;
      attackers_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      sld_q       <= sld_d;
      tgt_file_q  <= tgt_file_d;
      tgt_rank_q  <= tgt_rank_d;
      cur_file_q  <= cur_file_d;
      cur_rank_q  <= cur_rank_d;
      dir_q       <= dir_d;
      attackers_q <= attackers_d;
      count_q     <= count_d;
    end
  end

  assign busy         = (state_q == StWalk);
  assign done         = (state_q == StDone);
  assign attackers    = attackers_q;
  assign attack_count = count_q;

endmodule

// File: doc/diagonal_attackers.md
# diagonal_attackers

Sequential reverse-lookup for diagonal sliders. Given a target square, it walks the four diagonal rays outward from that square, one square per clock, and stops each ray at the first occupied square. It reports which enemy bishops or queens attack the target. It sits beside the combinational diagonal attack generator in the move/check logic and answers the inverse question: "who attacks this square?" rather than "what does this piece attack?". Square indexing matches the rest of the logic: bit index = rank*8 + file, with a1 = bit 0 and h8 = bit 63.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only in IDLE
- occupied  input  64  all-piece occupancy bitboard
- sliders  input  64  attacking-side bishops | queens bitboard
- file  input  3  target file (0 = a)
- rank  input  3  target rank (0 = 1)
- busy  output  1  high while in WALK
- done  output  1  one-cycle pulse; results valid
- attackers  output  64  bitboard of attacking sliders found
- attack_count  output  3  number of set bits in attackers (0..4)

## Operation
- States: IDLE, WALK, DONE.
- IDLE, start=1: latch occupied, sliders, file and rank. Set the direction to NE. Set the cursor to the target. Clear attackers and attack_count. Go to WALK.
- Direction order, as (file, rank) steps: NE (+1,+1), NW (-1,+1), SE (+1,-1), SW (-1,-1).
- Each WALK cycle computes next = cursor + step for the current direction:
  - next is off the board (file or rank would leave 0..7): this cycle only switches direction. No square is examined.
  - next is on the board and unoccupied: cursor <= next. The ray continues.
  - next is on the board and occupied: the ray terminates.
    - If the sliders bit of next is set, set attackers[next] and increment attack_count.
    - In all cases, switch direction.
- Switching direction resets the cursor to the target.
- Switching direction away from SW goes to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- The target square's own occupied and sliders bits are never examined.
- The sliders bit of an unoccupied square is ignored.
- start is ignored in WALK and DONE; no queueing.
- Changes to the data inputs after acceptance have no effect.
- attackers and attack_count hold their values from DONE until the next accepted start.

## Timing
- Reset (async assert) forces the following:
  - state = IDLE
  - busy = 0
  - done = 0
  - attackers = 0
  - attack_count = 0
  - all latched registers = 0
- Reset mid-WALK aborts the walk: no done pulse, and outputs are cleared.
- Cycle 0 is the edge at which start is sampled in IDLE. WALK occupies cycles 1..N with busy=1. Cycle N+1 is DONE with done=1 and busy=0. IDLE resumes at cycle N+2.
- attackers and attack_count read 0 from cycle 1. They may update during WALK. They are final in the DONE cycle.
- N = sum over the four rays of a per-ray term:
  - k, if the ray is blocked at the k-th square;
  - L + 1, if the ray runs off the board after its L empty on-board squares.
- Bounds: minimum N = 4 (all four neighbours occupied); maximum N = 17 (empty board, central squares).
- attack_count is a 3-bit saturating-free counter. At most 4 increments can occur, so it cannot overflow.
- There are no combinational paths from inputs to outputs. All outputs are registered.

## Test plan
- Empty board:
  - Stimulus: occupied = 0, sliders = 0, target d4 (file 3, rank 3).
  - Response: N = 17, with busy high for cycles 1..17. done is pulsed in cycle 18. attackers = 0, attack_count = 0.
- Long-diagonal corner:
  - Stimulus: target a1; occupied = sliders = 1<<63 (h8).
  - Response: N = 7 + 1 + 1 + 1 = 10. attackers = 64'h8000_0000_0000_0000, attack_count = 1.
- Blocker masking:
  - Stimulus: target d4; occupied = bits 45 | 63 | 9 (f6, h8, b2); sliders = bits 63 | 9.
  - Response: h8 is hidden behind the non-slider on f6, so only b2 attacks. attackers = 1<<9, attack_count = 1. N = 2 + 4 + 4 + 2 = 12.
- Four adjacent attackers:
  - Stimulus: target d4; occupied = sliders = bits 36 | 34 | 20 | 18 (e5, c5, e3, c3).
  - Response: N = 4, with done in cycle 5. attackers = 64'h0000_0014_0014_0000, attack_count = 4.
- Protocol robustness:
  - Case (a): Drive start again and change occupied, sliders, file and rank during WALK. Required: no effect on N or the results.
  - Case (b): Pull rst_n low in WALK cycle 3. Required: all outputs are 0 immediately and no done pulse occurs. After rst_n is released, a new start runs normally.
  - Case (c): Drive start high in the DONE cycle. Required: ignored. The results hold, and the next start is accepted in IDLE.
